// File: rtl/rmt_pkt_dispatcher_if.sv
// rmt_pkt_dispatcher_if: ingress stream, per-queue egress streams, tag FIFO pop port and packet counters
interface rmt_pkt_dispatcher_if #(
    parameter int W = 256,
    parameter int U = 128,
    parameter int N = 4
);
    logic [W-1:0]       s_axis_tdata;
    logic [U-1:0]       s_axis_tuser;
    logic [W/8-1:0]     s_axis_tkeep;
    logic               s_axis_tlast;
    logic               s_axis_tvalid;
    logic               s_axis_tready;
    logic [N*W-1:0]     m_axis_tdata;
    logic [N*U-1:0]     m_axis_tuser;
    logic [N*W/8-1:0]   m_axis_tkeep;
    logic [N-1:0]       m_axis_tlast;
    logic [N-1:0]       m_axis_tvalid;
    logic [N-1:0]       m_axis_tready;
    logic [N-1:0]       tag_onehot;
    logic               tag_valid;
    logic               tag_ready;
    logic [N*32-1:0]    pkt_cnt;
    modport slave (
        input  s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, m_axis_tready, tag_ready,
        output s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
               tag_onehot, tag_valid, pkt_cnt
    );
    modport master (
        output s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, m_axis_tready, tag_ready,
        input  s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
               tag_onehot, tag_valid, pkt_cnt
    );
endinterface

// File: rtl/rmt_pkt_dispatcher.sv
// rmt_pkt_dispatcher: steers whole packets round-robin to N queues and records each packet's queue in a tag FIFO
module rmt_pkt_dispatcher #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_QUEUES         = 4,
    parameter int C_SEL_MODE           = 0,
    parameter int C_TAG_FIFO_DEPTH     = 8
) (
    input logic axis_clk,
    input logic aresetn,
    rmt_pkt_dispatcher_if.slave bus
);
    localparam int N  = C_NUM_QUEUES;
    localparam int SW = $clog2(N);
    localparam int AW = $clog2(C_TAG_FIFO_DEPTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FWD  = 1'b1;
    logic [0:0]         state;
    logic [SW-1:0]      cur_sel;
    logic [SW-1:0]      inc_sel;
    logic [SW-1:0]      nxt_sel;
    logic [N-1:0]       tag_mem [C_TAG_FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic [N-1:0][31:0] cnt;
    logic               tag_full;
    logic               gate;
    logic               accept;
    logic               push;
    logic               pop;
    int                 j;
    assign bus.m_axis_tdata  = {N{bus.s_axis_tdata}};
    assign bus.m_axis_tuser  = {N{bus.s_axis_tuser}};
    assign bus.m_axis_tkeep  = {N{bus.s_axis_tkeep}};
    assign bus.m_axis_tlast  = {N{bus.s_axis_tlast}};
    // only a packet start waits for tag space; a packet already tagged always finishes
    assign tag_full          = count == (AW+1)'(C_TAG_FIFO_DEPTH);
    assign gate              = (state == FWD) | !tag_full;
    assign bus.s_axis_tready = bus.m_axis_tready[cur_sel] & gate;
    assign bus.m_axis_tvalid = (bus.s_axis_tvalid & gate) ? N'(1) << cur_sel : '0;
    assign accept            = bus.s_axis_tvalid & bus.s_axis_tready;
    assign push              = accept & (state == IDLE);
    assign pop               = bus.tag_ready & (count != '0);
    assign bus.tag_valid     = count != '0;
    assign bus.tag_onehot    = bus.tag_valid ? tag_mem[rd_ptr] : '0;
    assign bus.pkt_cnt       = cnt;
    assign inc_sel           = (cur_sel == SW'(N - 1)) ? '0 : cur_sel + 1'b1;
    // walk candidates farthest-first so the nearest ready queue after cur_sel wins
    always_comb begin
        nxt_sel = inc_sel;
        j = 0;
        if (C_SEL_MODE == 1)
            for (int k = N - 1; k >= 1; k--) begin
                j = int'(cur_sel) + k;
                j = (j >= N) ? j - N : j;
                nxt_sel = bus.m_axis_tready[j] ? SW'(j) : nxt_sel;
            end
    end
    always_ff @(posedge axis_clk or negedge aresetn)
        if (!aresetn) begin
            state   <= IDLE;
            cur_sel <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            cnt     <= '0;
        end else begin
            if (accept && bus.s_axis_tlast) begin
                state   <= IDLE;
                cur_sel <= nxt_sel;
            end else if (push)
                state <= FWD;
            if (push) begin
                wr_ptr       <= wr_ptr + 1'b1;
                cnt[cur_sel] <= cnt[cur_sel] + 32'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    always_ff @(posedge axis_clk)
        if (push)
            tag_mem[wr_ptr] <= N'(1) << cur_sel;
endmodule

// File: doc/rmt_pkt_dispatcher.md
# rmt_pkt_dispatcher

Parametrised packet dispatcher between the RMT ingress AXI-Stream and the per-queue packet data caches. It steers whole packets to one of C_NUM_QUEUES output streams under true AXI backpressure and pushes a one-hot queue tag per packet into a tag FIFO. The PHV tagging logic pops that FIFO, so each header vector carries the queue that actually holds its payload. It supports strict round-robin and ready-skipping round-robin selection.

## Interface
- C_S_AXIS_DATA_WIDTH, 256, data bus width
- C_S_AXIS_TUSER_WIDTH, 128, tuser width
- C_NUM_QUEUES, 4, output queue count (2..16)
- C_SEL_MODE, 0, 0 = strict round-robin, 1 = skip-not-ready round-robin
- C_TAG_FIFO_DEPTH, 8, tag FIFO entries (power of 2, >=2)
- axis_clk  in  1  clock; one clock, all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- s_axis_tdata/tuser/tkeep/tlast/tvalid  in  W/U/W/8/1/1  ingress packet stream
- s_axis_tready  out  1  ingress ready
- m_axis_tdata  out  N*W  data, replicated per queue; slice q = bits [q*W +: W]
- m_axis_tuser  out  N*U  tuser, replicated per queue
- m_axis_tkeep  out  N*W/8  tkeep, replicated per queue
- m_axis_tlast  out  N  tlast, replicated per queue
- m_axis_tvalid  out  N  per-queue valid
- m_axis_tready  in  N  per-queue ready
- tag_onehot  out  N  one-hot queue of oldest untagged packet
- tag_valid  out  1  tag FIFO non-empty
- tag_ready  in  1  tag consumer pop
- pkt_cnt  out  N*32  per-queue accepted-packet counters, wrap at 2^32

## Operation
- Registers: state {IDLE, FWD}; cur_sel (log2 N bits); tag FIFO with occupancy count; pkt_cnt[N].
- Data path combinational: every m_axis slice carries s_axis data, tuser, tkeep and tlast. Only m_axis_tvalid[cur_sel] may be 1.
- IDLE: m_axis_tvalid[cur_sel] = s_axis_tvalid & !tag_full; s_axis_tready = m_axis_tready[cur_sel] & !tag_full.
- FWD: m_axis_tvalid[cur_sel] = s_axis_tvalid; s_axis_tready = m_axis_tready[cur_sel]. The tag FIFO state has no effect.
- Beat accepted = s_axis_tvalid & s_axis_tready.
- First beat accepted in IDLE:
  - push the one-hot of cur_sel into the tag FIFO;
  - increment pkt_cnt[cur_sel];
  - if tlast = 0, go to FWD; if tlast = 1 (single-beat packet), stay in IDLE and advance cur_sel.
- tlast accepted in FWD: advance cur_sel; go to IDLE.
- Advance, mode 0: cur_sel + 1, wrapping N-1 -> 0.
- Advance, mode 1: the first queue in rotating order cur_sel+1 .. cur_sel+N-1 whose m_axis_tready is 1 in the tlast cycle. If none is ready, use cur_sel + 1. The current queue is never chosen again back-to-back.
- cur_sel changes only on an accepted tlast. Selection therefore never depends on the same-cycle ready, and tvalid never depends on tready.
- Tag FIFO:
  - tag_full = (count == C_TAG_FIFO_DEPTH); computed from registered count.
  - A pop while full does not unblock a push in the same cycle.
  - Push and pop in the same cycle with 0 < count < DEPTH leaves count unchanged.
  - A pop when empty is ignored.
- Reset, including mid-packet: state = IDLE, cur_sel = 0, FIFO emptied, counters = 0. A truncated in-flight packet is not completed; downstream caches flush on reset.

## Timing
- Reset values: s_axis_tready = m_axis_tready[0] & 1 (FIFO empty); m_axis_tvalid = 0 unless s_axis_tvalid; tag_valid = 0; tag_onehot = 0; pkt_cnt = 0.
- Data latency is 0 cycles (pass-through). No bubble between packets; back-to-back packets go to consecutive queues.
- The tag becomes visible the cycle after the first-beat acceptance: tag_valid is registered and tag_onehot comes from registered FIFO head.
- pkt_cnt updates the cycle after the first-beat acceptance.
- AXI rules hold on every stream: m_axis_tvalid stays stable while its ready is low, as long as s_axis_tvalid is held.

## Test plan
- N=4, mode 0, all readies 1, eight 3-beat packets -> queues 0,1,2,3,0,1,2,3; tags 0001,0010,0100,1000 repeating; pkt_cnt = 2 each.
- Mode 0, m_axis_tready[1] = 0 for 20 cycles while packet 2 is pending -> s_axis_tready = 0 and the packet is held on queue 1, not redirected. After ready returns, the packet completes on queue 1.
- Mode 1, at tlast of the queue-0 packet m_axis_tready = 4'b1001 -> next cur_sel = 3. With readies 4'b0001 -> cur_sel = 1 (fallback).
- Depth 8, tag_ready = 0, ten 1-beat packets -> exactly 8 accepted, s_axis_tready low from the 9th. One pop -> a 9th packet is accepted the cycle after.
- Reset asserted on beat 2 of a 4-beat packet -> immediately state IDLE, cur_sel 0, tag_valid 0. The next packet goes to queue 0 with tag 0001.
- N=8, width 512, 1-beat packets with tlast = 1 every cycle -> one packet per cycle, cur_sel wraps 7 -> 0, all pkt_cnt equal after 64 packets.
